// File: rtl/vpu_sram_rd_arbiter_pkg.sv
// Shared types and defaults for the VPU SRAM read-port arbiter.
// Bank geometry constants mirror the SRAM macro configuration.
package vpu_sram_rd_arbiter_pkg;

  localparam int unsigned SRAM_BANK_CNT_LG2   = 2;
  localparam int unsigned SRAM_BANK_DEPTH_LG2 = 10;
  localparam int unsigned SRAM_DATA_WIDTH     = 32;

  localparam int unsigned ARB_REQ_CNT   = 3;
  localparam int unsigned TAG_W         = $clog2(ARB_REQ_CNT);
  localparam int unsigned ARB_TAG_DEPTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vpu_arb_tag_fifo.sv
// In-order tag FIFO remembering which requester issued each accepted beat.
// DEPTH must be a power of two so the pointers wrap naturally.
module vpu_arb_tag_fifo
  import vpu_sram_rd_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = TAG_W,
  parameter int unsigned DEPTH = ARB_TAG_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vpu_sram_rd_arbiter.sv
// Round-robin arbiter with burst lock sharing one SRAM read port among
// VPU source ports; read data is steered back via an in-order tag FIFO.
module vpu_sram_rd_arbiter
  import vpu_sram_rd_arbiter_pkg::*;
#(
  parameter int unsigned REQ_CNT   = ARB_REQ_CNT,
  parameter int unsigned BANK_LG2  = SRAM_BANK_CNT_LG2,
  parameter int unsigned ADDR_W    = SRAM_BANK_DEPTH_LG2,
  parameter int unsigned DATA_W    = SRAM_DATA_WIDTH,
  parameter int unsigned TAG_DEPTH = ARB_TAG_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_CNT-1:0]           s_req_i,
  input  logic [REQ_CNT*BANK_LG2-1:0]  s_rid_i,
  input  logic [REQ_CNT*ADDR_W-1:0]    s_addr_i,
  input  logic [REQ_CNT-1:0]           s_reb_i,
  input  logic [REQ_CNT-1:0]           s_rlast_i,
  output logic [REQ_CNT-1:0]           s_ack_o,
  output logic [REQ_CNT*DATA_W-1:0]    s_rdata_o,
  output logic [REQ_CNT-1:0]           s_rvalid_o,
  output logic                         m_req_o,
  output logic [BANK_LG2-1:0]          m_rid_o,
  output logic [ADDR_W-1:0]            m_addr_o,
  output logic                         m_reb_o,
  output logic                         m_rlast_o,
  input  logic                         m_ack_i,
  input  logic [DATA_W-1:0]            m_rdata_i,
  input  logic                         m_rvalid_i,
  output logic                         err_o
);

  localparam int unsigned IDX_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_nxt;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] owner_nxt;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] sel_inc;
  logic             sel_vld;
  logic             xfer;
  logic             pop;
  logic             tag_full;
  logic             tag_empty;
  logic [IDX_W-1:0] tag_head;
  int unsigned      scan_idx;

  // Locked to the owner during a burst; otherwise scan upward from rr_ptr.
  always_comb begin
    sel      = '0;
    sel_vld  = 1'b0;
    scan_idx = 0;
    if (state == BURST) begin
      sel     = owner;
      sel_vld = s_req_i[owner];
    end else begin
      for (int unsigned i = 0; i < REQ_CNT; i++) begin
        scan_idx = int'(rr_ptr) + i;
        if (scan_idx >= REQ_CNT) begin
          scan_idx = scan_idx - REQ_CNT;
        end
        if (!sel_vld && s_req_i[scan_idx]) begin
          sel     = IDX_W'(scan_idx);
          sel_vld = 1'b1;
        end
      end
    end
  end

  assign sel_inc = (sel == IDX_W'(REQ_CNT - 1)) ? '0 : sel + 1'b1;

  // Full blocks the request even if a pop frees a slot this same cycle.
  always_comb begin
    m_req_o   = 1'b0;
    m_rid_o   = '0;
    m_addr_o  = '0;
    m_reb_o   = 1'b0;
    m_rlast_o = 1'b0;
    if (!rst && sel_vld) begin
      m_req_o = !tag_full;
      for (int unsigned i = 0; i < REQ_CNT; i++) begin
        if (sel == IDX_W'(i)) begin
          m_rid_o   = s_rid_i[i*BANK_LG2 +: BANK_LG2];
          m_addr_o  = s_addr_i[i*ADDR_W +: ADDR_W];
          m_reb_o   = s_reb_i[i];
          m_rlast_o = s_rlast_i[i];
        end
      end
    end
  end

  assign xfer = m_req_o && m_ack_i;
  assign pop  = !rst && m_rvalid_i && !tag_empty;

  always_comb begin
    s_ack_o    = '0;
    s_rvalid_o = '0;
    s_rdata_o  = '0;
    for (int unsigned i = 0; i < REQ_CNT; i++) begin
      if (xfer && sel == IDX_W'(i)) begin
        s_ack_o[i] = 1'b1;
      end
      if (pop && tag_head == IDX_W'(i)) begin
        s_rvalid_o[i]                 = 1'b1;
        s_rdata_o[i*DATA_W +: DATA_W] = m_rdata_i;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    if (xfer) begin
      if (m_rlast_o) begin
        state_nxt = IDLE;
        rr_nxt    = sel_inc;
      end else if (state == IDLE) begin
        state_nxt = BURST;
        owner_nxt = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      err_o  <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_nxt;
      if (m_rvalid_i && tag_empty) begin
        err_o <= 1'b1;
      end
    end
  end

  vpu_arb_tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (xfer),
    .push_data (sel),
    .pop       (pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

endmodule

// File: tb/tb_vpu_sram_rd_arbiter.sv
// Randomized bench for vpu_sram_rd_arbiter against a queue-based reference
// model of round-robin/burst-lock grants and in-order read return routing.
module tb_vpu_sram_rd_arbiter;

  localparam int N  = 3;
  localparam int BL = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TD = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    s_req;
  logic [N*BL-1:0] s_rid;
  logic [N*AW-1:0] s_addr;
  logic [N-1:0]    s_reb;
  logic [N-1:0]    s_rlast;
  logic [N-1:0]    s_ack;
  logic [N*DW-1:0] s_rdata;
  logic [N-1:0]    s_rvalid;
  logic            m_req;
  logic [BL-1:0]   m_rid;
  logic [AW-1:0]   m_addr;
  logic            m_reb;
  logic            m_rlast;
  logic            m_ack;
  logic [DW-1:0]   m_rdata;
  logic            m_rvalid;
  logic            err;

  vpu_sram_rd_arbiter #(
    .REQ_CNT   (N),
    .BANK_LG2  (BL),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TAG_DEPTH (TD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_req_i    (s_req),
    .s_rid_i    (s_rid),
    .s_addr_i   (s_addr),
    .s_reb_i    (s_reb),
    .s_rlast_i  (s_rlast),
    .s_ack_o    (s_ack),
    .s_rdata_o  (s_rdata),
    .s_rvalid_o (s_rvalid),
    .m_req_o    (m_req),
    .m_rid_o    (m_rid),
    .m_addr_o   (m_addr),
    .m_reb_o    (m_reb),
    .m_rlast_o  (m_rlast),
    .m_ack_i    (m_ack),
    .m_rdata_i  (m_rdata),
    .m_rvalid_i (m_rvalid),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: grant pointer, optional lock owner, outstanding tags.
  int mdl_rr    = 0;
  int mdl_owner = 0;
  bit mdl_lock  = 0;
  bit mdl_err   = 0;
  int tagq[$];

  // Stimulus state: beats remaining per requester, SRAM return schedule.
  int left[N];
  int adv      = -1;
  int p_start  = 0;
  int max_len  = 1;
  int p_ack    = 100;
  int dmin     = 2;
  int dmax     = 2;
  bit hold_ret = 0;
  bit inject   = 0;
  int due_q[$];
  int last_due = 0;
  int cyc      = 0;

  task automatic new_beat(input int r);
    s_rid[r*BL +: BL]  = BL'($urandom);
    s_addr[r*AW +: AW] = AW'($urandom);
    s_reb[r]           = 1'($urandom);
    s_rlast[r]         = (left[r] == 1);
    s_req[r]           = 1'b1;
  endtask

  task automatic step();
    logic          e_req, e_reb, e_rlast, xfer;
    logic [BL-1:0] e_rid;
    logic [AW-1:0] e_addr;
    logic [N-1:0]  e_ack, e_rv;
    logic [N*DW-1:0] e_rd;
    int sel, c, d;

    if (adv >= 0) begin
      left[adv]--;
      if (left[adv] > 0) new_beat(adv);
      adv = -1;
    end
    for (int r = 0; r < N; r++) begin
      if (left[r] == 0 && int'($urandom_range(99)) < p_start) begin
        left[r] = 1 + int'($urandom_range(max_len - 1));
        new_beat(r);
      end
      if (left[r] == 0) s_req[r] = 1'b0;
    end
    m_ack   = int'($urandom_range(99)) < p_ack;
    m_rdata = $urandom;
    if (!hold_ret && due_q.size() > 0 && due_q[0] <= cyc) begin
      m_rvalid = 1'b1;
      void'(due_q.pop_front());
    end else begin
      m_rvalid = inject;
    end

    #4;
    e_req = 0; e_rid = '0; e_addr = '0; e_reb = 0; e_rlast = 0;
    e_ack = '0; e_rv = '0; e_rd = '0; sel = -1; xfer = 0;
    if (!rst) begin
      if (mdl_lock) begin
        if (s_req[mdl_owner]) sel = mdl_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (mdl_rr + k) % N;
          if (sel < 0 && s_req[c]) sel = c;
        end
      end
      if (sel >= 0) begin
        e_req   = (tagq.size() < TD);
        e_rid   = s_rid[sel*BL +: BL];
        e_addr  = s_addr[sel*AW +: AW];
        e_reb   = s_reb[sel];
        e_rlast = s_rlast[sel];
      end
      xfer = e_req && m_ack;
      if (xfer) e_ack[sel] = 1'b1;
      if (m_rvalid && tagq.size() > 0) begin
        e_rv[tagq[0]]          = 1'b1;
        e_rd[tagq[0]*DW +: DW] = m_rdata;
      end
    end
    check_eq("m_req", 128'(m_req), 128'(e_req));
    check_eq("m_rid", 128'(m_rid), 128'(e_rid));
    check_eq("m_addr", 128'(m_addr), 128'(e_addr));
    check_eq("m_reb", 128'(m_reb), 128'(e_reb));
    check_eq("m_rlast", 128'(m_rlast), 128'(e_rlast));
    check_eq("s_ack", 128'(s_ack), 128'(e_ack));
    check_eq("s_rvalid", 128'(s_rvalid), 128'(e_rv));
    check_eq("s_rdata", 128'(s_rdata), 128'(e_rd));
    check_eq("err", 128'(err), 128'(mdl_err));

    if (rst) begin
      mdl_rr = 0; mdl_lock = 0; mdl_err = 0;
      tagq.delete();
      due_q.delete();
    end else begin
      if (m_rvalid) begin
        if (tagq.size() > 0) void'(tagq.pop_front());
        else mdl_err = 1;
      end
      if (xfer) begin
        tagq.push_back(sel);
        if (e_rlast) begin
          mdl_rr   = (sel + 1) % N;
          mdl_lock = 0;
        end else begin
          mdl_lock  = 1;
          mdl_owner = sel;
        end
        adv = sel;
        d = cyc + dmin + int'($urandom_range(dmax - dmin));
        if (d <= last_due) d = last_due + 1;
        due_q.push_back(d);
        last_due = d;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    bit done;
    p_start = 0;
    p_ack   = 100;
    done    = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      done = (left[0] == 0 && left[1] == 0 && left[2] == 0 && adv < 0 &&
              due_q.size() == 0 && tagq.size() == 0);
      if (!done) step();
    end
    check_eq("drain_timeout", 128'(done), 128'(1));
  endtask

  initial begin
    for (int r = 0; r < N; r++) left[r] = 0;
    s_req = '0; s_rid = '0; s_addr = '0; s_reb = '0; s_rlast = '0;
    m_ack = 1'b0; m_rdata = '0; m_rvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // All three single beats, always acked, data back after 2 cycles.
    p_start = 100; max_len = 1; p_ack = 100; dmin = 2; dmax = 2;
    repeat (12) step();

    // Requester 1 bursts 4 beats while 0 and 2 wait with single beats.
    drain();
    left[0] = 1; left[1] = 4; left[2] = 1;
    for (int r = 0; r < N; r++) new_beat(r);
    repeat (10) step();

    // Withheld returns fill the tag FIFO, then release them.
    drain();
    hold_ret = 1; p_start = 100; max_len = 3;
    repeat (8) step();
    hold_ret = 0;
    repeat (12) step();

    // Long random run.
    p_start = 40; max_len = 4; p_ack = 70; dmin = 1; dmax = 5;
    repeat (3000) step();

    // Reset in the middle of a burst; requester 0 must win afterwards.
    drain();
    left[1] = 4;
    new_beat(1);
    repeat (2) step();
    rst = 1'b1;
    left[0] = 1;
    new_beat(0);
    repeat (2) step();
    rst = 1'b0;
    repeat (8) step();

    // Read data with nothing outstanding raises a sticky error.
    drain();
    inject = 1;
    step();
    inject = 0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vpu_sram_rd_arbiter.md
Name: vpu_sram_rd_arbiter

Overview:
- Shares one SRAM read port among REQ_CNT VPU source-port requesters (src0/src1/src2 of the VPU top).
- Round-robin arbitration with burst lock: a grant holds from the first beat until the beat carrying rlast.
- Returned read data is routed back to the issuing requester through an in-order tag FIFO.
- Sits between the VPU source-port interfaces and the SRAM bank read port.

Parameters:
- REQ_CNT, 3, number of requesters (≥2).
- BANK_LG2, SRAM_BANK_CNT_LG2, bank-id width.
- ADDR_W, SRAM_BANK_DEPTH_LG2, bank address width.
- DATA_W, SRAM_DATA_WIDTH, read data width.
- TAG_DEPTH, 4, maximum outstanding accepted beats without returned data (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- s_req_i  in  REQ_CNT  per-requester beat request.
- s_rid_i  in  BANK_LG2 x REQ_CNT  bank id.
- s_addr_i  in  ADDR_W x REQ_CNT  address.
- s_reb_i  in  REQ_CNT  read enable (active-low), forwarded unchanged.
- s_rlast_i  in  REQ_CNT  last beat of burst.
- s_ack_o  out  REQ_CNT  beat accepted.
- s_rdata_o  out  DATA_W x REQ_CNT  read data.
- s_rvalid_o  out  REQ_CNT  read data valid.
- m_req_o, m_rid_o, m_addr_o, m_reb_o, m_rlast_o  out  1/BANK_LG2/ADDR_W/1/1  to SRAM port.
- m_ack_i  in  1  SRAM accepted beat.
- m_rdata_i  in  DATA_W  SRAM read data.
- m_rvalid_i  in  1  SRAM read data valid.
- err_o  out  1  sticky: rvalid received with no outstanding tag.

Behaviour:
- Beat transfer: m_req_o & m_ack_i in the same cycle. Requesters hold req/rid/addr/rlast stable until acked.
- Reset state:
  - FSM IDLE, rr_ptr=0, tag FIFO empty, err_o=0.
  - All m_* outputs, s_ack_o and s_rvalid_o are 0; s_rdata_o is 0.
- FSM IDLE:
  - Winner = first asserted s_req_i scanning from rr_ptr upward, with wrap.
  - The winner's fields are forwarded combinationally to m_*; s_ack_o[winner] = m_ack_i & m_req_o.
  - Transfer with rlast=1 → stay IDLE; rr_ptr = winner+1 mod REQ_CNT.
  - Transfer with rlast=0 → BURST; owner = winner.
  - No transfer → no state change, and the winner may change next cycle.
- FSM BURST:
  - Only the owner is forwarded; other requesters see ack=0.
  - Transfer with rlast=1 → IDLE; rr_ptr = owner+1 mod REQ_CNT.
  - Owner req low → m_req_o=0 and the FSM stays in BURST. There is no timeout.
- Tag FIFO:
  - Each transfer pushes the requester index. Each m_rvalid_i pops the head.
  - On pop, s_rvalid_o[head] = 1 and s_rdata_o[head] = m_rdata_i, combinationally in the same cycle. Zero added latency.
  - Non-selected s_rdata_o lanes are 0.
- FIFO full: m_req_o is forced 0, even if a pop occurs the same cycle. This is conservative and adds one bubble.
- Push and pop in the same cycle when not full: count unchanged; pointers wrap mod TAG_DEPTH.
- Empty FIFO with m_rvalid_i=1: err_o sets and holds until rst; the beat is dropped and no s_rvalid_o is asserted.
- Reset mid-burst: lock released and outstanding tags discarded; late SRAM returns then raise err_o (the integration must drain first).
- The pointer is updated only on burst completion; the requester order is fair within REQ_CNT bursts.

Decomposition:
- VPU_PKG additions:
  - arb_state_e {IDLE, BURST}.
  - TAG_W = $clog2(REQ_CNT).
  - Default TAG_DEPTH constant.
- Sub-module vpu_arb_tag_fifo: sync FIFO of TAG_W entries with full/empty flags and push/pop.
- Round-robin pick and FSM live in the top.

Test Plan:
- Single beats, all three requesting simultaneously, m_ack_i=1 always → grants in order 0,1,2,0; m_rid/m_addr match each winner; rr_ptr wraps.
- Requester1 issues a 4-beat burst (rlast on beat 4) while req0 and req2 are held → only s_ack_o[1] for 4 transfers; next grant goes to req2.
- SRAM returns m_rvalid_i 2 cycles after each ack, with data 0xA0+n → s_rvalid_o/s_rdata_o arrive on the issuing lane in order with the correct data.
- m_rvalid_i held 0 after 4 transfers → 5th beat is blocked (m_req_o=0); one m_rvalid_i pulse → m_req_o reasserts the next cycle.
- m_rvalid_i=1 with empty FIFO → err_o=1 and stays 1; no s_rvalid_o.
- rst asserted mid-burst (beat 2 of 4) → next cycle all outputs are 0 and the FSM is IDLE; after release, requester0 wins (rr_ptr=0).
